// File: rtl/spu_pkg.sv
// Shared definitions for the spatial processing unit operand path.
package spu_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned OP_W    = 4;

  // Encoding 3 is unused and recovers to S_AB.
  typedef enum logic [1:0] {
    S_AB    = 2'd0,
    S_CD    = 2'd1,
    S_ISSUE = 2'd2
  } spu_state_e;

  localparam logic [OP_W-1:0] OP_MANHATTAN = OP_W'(0);
  localparam logic [OP_W-1:0] OP_BOXAREA   = OP_W'(1);

endpackage

// File: rtl/spu_operand_loader_if.sv
// Beat input bus and assembled operand output bus of the operand loader.
interface spu_operand_loader_if;
  import spu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2*COORD_W-1:0] in_data;
  logic [OP_W-1:0]      in_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [COORD_W-1:0]   out_a;
  logic [COORD_W-1:0]   out_b;
  logic [COORD_W-1:0]   out_c;
  logic [COORD_W-1:0]   out_d;
  logic [OP_W-1:0]      out_op;

  // Producer of beats and consumer of operand sets.
  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d, out_op
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d, out_op
  );

endinterface

// File: rtl/spu_beat_timer.sv
// Inter-beat timer: counts stalled edges and flags the last permitted one.
module spu_beat_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] r_cnt;

  // Clear dominates; otherwise count while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_expire
      assign o_expire = (r_cnt == TW'(TIMEOUT - 1));
    end else begin : g_no_expire
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spu_operand_loader.sv
// Two-beat operand assembler with valid/ready issue, beat timeout and abort.
module spu_operand_loader
  import spu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  spu_operand_loader_if.slave bus,
  input  logic                abort,
  output logic                timeout_err,
  output logic [1:0]          state_o
);

  spu_state_e         r_state, w_state_d;
  logic               r_out_valid;
  logic               r_timeout_err;
  logic [COORD_W-1:0] r_a, r_b, r_c, r_d;
  logic [OP_W-1:0]    r_op;

  logic w_in_ready, w_accept, w_handshake;
  logic w_ld_ab, w_ld_cd, w_tmo;
  logic w_timer_clr, w_timer_en, w_expire;

  assign w_in_ready  = (r_state == S_AB) || (r_state == S_CD);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_handshake = r_out_valid && bus.out_ready;

  spu_beat_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  // Next-state and load strobes; abort overrides everything decided above it.
  always_comb begin
    w_state_d   = r_state;
    w_ld_ab     = 1'b0;
    w_ld_cd     = 1'b0;
    w_tmo       = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_en  = 1'b0;
    case (r_state)
      S_AB: begin
        w_timer_clr = 1'b1;
        if (w_accept) begin
          w_ld_ab   = 1'b1;
          w_state_d = S_CD;
        end
      end
      S_CD: begin
        // An accept on the expiry edge wins over the timeout.
        if (w_accept) begin
          w_ld_cd     = 1'b1;
          w_timer_clr = 1'b1;
          w_state_d   = S_ISSUE;
        end else if (w_expire) begin
          w_tmo       = 1'b1;
          w_timer_clr = 1'b1;
          w_state_d   = S_AB;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      S_ISSUE: begin
        w_timer_clr = 1'b1;
        if (w_handshake) begin
          w_state_d = S_AB;
        end
      end
      default: begin
        w_timer_clr = 1'b1;
        w_state_d   = S_AB;
      end
    endcase
    if (abort) begin
      w_state_d   = S_AB;
      w_ld_ab     = 1'b0;
      w_ld_cd     = 1'b0;
      w_tmo       = 1'b0;
      w_timer_clr = 1'b1;
      w_timer_en  = 1'b0;
    end
  end

  // State, status and operand registers; operands hold until overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_AB;
      r_out_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_d           <= '0;
      r_op          <= '0;
    end else begin
      r_state       <= w_state_d;
      r_out_valid   <= (w_state_d == S_ISSUE);
      r_timeout_err <= w_tmo;
      if (w_ld_ab) begin
        r_a  <= bus.in_data[2*COORD_W-1:COORD_W];
        r_b  <= bus.in_data[COORD_W-1:0];
        r_op <= bus.in_op;
      end
      if (w_ld_cd) begin
        r_c <= bus.in_data[2*COORD_W-1:COORD_W];
        r_d <= bus.in_data[COORD_W-1:0];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_a;
  assign bus.out_b     = r_b;
  assign bus.out_c     = r_c;
  assign bus.out_d     = r_d;
  assign bus.out_op    = r_op;
  assign timeout_err   = r_timeout_err;
  assign state_o       = r_state;

endmodule

// File: tb/tb_spu_operand_loader.sv
// Directed bench for spu_operand_loader with TIMEOUT=4.
module tb_spu_operand_loader;
  import spu_pkg::*;

  logic       clk;
  logic       reset;
  logic       abort;
  logic       timeout_err;
  logic [1:0] state_o;
  int         n_checks;
  int         n_fail;

  spu_operand_loader_if bus_if ();

  spu_operand_loader #(
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .abort       (abort),
    .timeout_err (timeout_err),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic [7:0] data, input logic [3:0] op);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = data;
    bus_if.in_op    = op;
    step();
    bus_if.in_valid = 1'b0;
  endtask

  function automatic logic [15:0] ops();
    return {bus_if.out_a, bus_if.out_b, bus_if.out_c, bus_if.out_d};
  endfunction

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    abort            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_op     = '0;
    bus_if.out_ready = 1'b0;
    #1;
    check("rst_state", 16'(state_o), 16'h0);
    check("rst_valid", 16'(bus_if.out_valid), 16'h0);
    check("rst_ready", 16'(bus_if.in_ready), 16'h1);
    check("rst_err", 16'(timeout_err), 16'h0);
    check("rst_ops", ops(), 16'h0000);
    check("rst_op", 16'(bus_if.out_op), 16'h0);
    step();
    reset = 1'b0;
    step();

    // Basic issue.
    beat(8'h35, OP_BOXAREA);
    check("b0_state", 16'(state_o), 16'h1);
    check("b0_valid", 16'(bus_if.out_valid), 16'h0);
    beat(8'h72, OP_MANHATTAN);
    check("iss_valid", 16'(bus_if.out_valid), 16'h1);
    check("iss_ops", ops(), 16'h3572);
    check("iss_op", 16'(bus_if.out_op), 16'(OP_BOXAREA));
    check("iss_ready", 16'(bus_if.in_ready), 16'h0);

    // Backpressure, then handshake with a beat offered in the same cycle.
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 16'(bus_if.out_valid), 16'h1);
      check("bp_ready", 16'(bus_if.in_ready), 16'h0);
      check("bp_ops", ops(), 16'h3572);
    end
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 8'h11;
    step();
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b0;
    check("hs_valid", 16'(bus_if.out_valid), 16'h0);
    check("hs_ready", 16'(bus_if.in_ready), 16'h1);
    check("hs_nobypass", 16'(state_o), 16'h0);
    check("hs_ops_kept", ops(), 16'h3572);

    // Timeout after four idle edges.
    beat(8'h46, OP_MANHATTAN);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_wait_state", 16'(state_o), 16'h1);
      check("to_wait_err", 16'(timeout_err), 16'h0);
    end
    step();
    check("to_err", 16'(timeout_err), 16'h1);
    check("to_state", 16'(state_o), 16'h0);
    check("to_valid", 16'(bus_if.out_valid), 16'h0);
    beat(8'h9A, OP_BOXAREA);
    check("to_err_pulse", 16'(timeout_err), 16'h0);
    check("to_new_a", 16'(bus_if.out_a), 16'h9);
    check("to_new_b", 16'(bus_if.out_b), 16'hA);
    check("to_new_state", 16'(state_o), 16'h1);

    // Beat1 exactly on the expiry edge wins.
    for (int i = 0; i < 3; i++) step();
    beat(8'hBC, OP_MANHATTAN);
    check("race_valid", 16'(bus_if.out_valid), 16'h1);
    check("race_state", 16'(state_o), 16'h2);
    check("race_err", 16'(timeout_err), 16'h0);
    check("race_ops", ops(), 16'h9ABC);
    check("race_op", 16'(bus_if.out_op), 16'(OP_BOXAREA));
    step();
    check("race_err2", 16'(timeout_err), 16'h0);
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    check("race_hs", 16'(bus_if.out_valid), 16'h0);

    // Abort in S_CD with a concurrent beat.
    beat(8'h12, OP_MANHATTAN);
    abort           = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h34;
    step();
    abort           = 1'b0;
    bus_if.in_valid = 1'b0;
    check("abcd_state", 16'(state_o), 16'h0);
    check("abcd_valid", 16'(bus_if.out_valid), 16'h0);
    check("abcd_err", 16'(timeout_err), 16'h0);
    check("abcd_ops", ops(), 16'h12BC);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abcd_noerr", 16'(timeout_err), 16'h0);
    end

    // Abort in S_ISSUE with out_ready high.
    beat(8'h56, OP_BOXAREA);
    beat(8'h78, OP_MANHATTAN);
    check("abis_pre", 16'(bus_if.out_valid), 16'h1);
    abort            = 1'b1;
    bus_if.out_ready = 1'b1;
    step();
    abort            = 1'b0;
    bus_if.out_ready = 1'b0;
    check("abis_state", 16'(state_o), 16'h0);
    check("abis_valid", 16'(bus_if.out_valid), 16'h0);
    check("abis_err", 16'(timeout_err), 16'h0);
    check("abis_ops", ops(), 16'h5678);

    // Asynchronous reset while issuing.
    beat(8'h21, OP_BOXAREA);
    beat(8'h43, OP_MANHATTAN);
    check("ar_pre", 16'(bus_if.out_valid), 16'h1);
    reset = 1'b1;
    #1;
    check("ar_valid", 16'(bus_if.out_valid), 16'h0);
    check("ar_ops", ops(), 16'h0000);
    check("ar_op", 16'(bus_if.out_op), 16'h0);
    check("ar_state", 16'(state_o), 16'h0);
    check("ar_ready", 16'(bus_if.in_ready), 16'h1);
    #2;
    reset = 1'b0;
    step();
    beat(8'hDE, OP_BOXAREA);
    beat(8'hF0, OP_MANHATTAN);
    check("ar_new_valid", 16'(bus_if.out_valid), 16'h1);
    check("ar_new_ops", ops(), 16'hDEF0);
    check("ar_new_op", 16'(bus_if.out_op), 16'(OP_BOXAREA));
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    check("ar_new_hs", 16'(bus_if.out_valid), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
